// File: rtl/macro_pick1_pkg.sv
// Shared constants for the pick-one arbiter family: selection policy encodings.
package macro_pick1_pkg;

  localparam int PICK1_MODE_LF = 0;
  localparam int PICK1_MODE_HF = 1;
  localparam int PICK1_MODE_RR = 2;

  typedef enum logic [1:0] {
    PICK1_LF = 2'd0,
    PICK1_HF = 2'd1,
    PICK1_RR = 2'd2
  } pick1_mode_e;

  function automatic bit pick1_high_first(input int mode);
    return (mode == PICK1_MODE_HF);
  endfunction

  function automatic bit pick1_is_rr(input int mode);
    return (mode == PICK1_MODE_RR);
  endfunction

endpackage

// File: rtl/macro_pick1_arbiter_bin_pick.sv
// Combinational log-depth priority tree: returns {valid, index} of the lowest
// (or highest, when HIGH_FIRST) set request bit.
module macro_pick1_arbiter_bin_pick #(
  parameter int N          = 4,
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic [N-1:0]         i_req,
  output logic                 o_valid,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int AW = $clog2(N);
  localparam int P  = 1 << AW;

  logic [P-1:0]  w_req_pad;
  logic          w_v  [AW+1][P];
  logic [AW-1:0] w_ix [AW+1][P];

  // Padding leaves beyond N are tied off so they can never win.
  assign w_req_pad = P'(i_req);

  always_comb begin
    for (int l = 0; l <= AW; l++) begin
      for (int j = 0; j < P; j++) begin
        w_v[l][j]  = 1'b0;
        w_ix[l][j] = '0;
      end
    end
    for (int i = 0; i < P; i++) begin
      w_v[0][i]  = w_req_pad[i];
      w_ix[0][i] = AW'(i);
    end
    for (int l = 1; l <= AW; l++) begin
      for (int j = 0; j < (P >> l); j++) begin
        w_v[l][j] = w_v[l-1][2*j] | w_v[l-1][2*j+1];
        if (HIGH_FIRST)
          w_ix[l][j] = w_v[l-1][2*j+1] ? w_ix[l-1][2*j+1] : w_ix[l-1][2*j];
        else
          w_ix[l][j] = w_v[l-1][2*j] ? w_ix[l-1][2*j] : w_ix[l-1][2*j+1];
      end
    end
    o_valid = w_v[AW][0];
    o_idx   = w_ix[AW][0];
  end

endmodule

// File: rtl/macro_pick1_arbiter_bin.sv
// Registered pick-one arbiter with binary grant index, flow control on qready,
// and fixed-low, fixed-high or round-robin selection.
module macro_pick1_arbiter_bin
  import macro_pick1_pkg::*;
#(
  parameter int INPUT_COUNT = 4,
  parameter int MODE        = PICK1_MODE_LF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [INPUT_COUNT-1:0]         dvalid,
  input  logic                           qready,
  output logic                           qvalid,
  output logic [$clog2(INPUT_COUNT)-1:0] qaddr,
  output logic [INPUT_COUNT-1:0]         dgrant
);

  localparam int AW = $clog2(INPUT_COUNT);
  localparam bit RR = pick1_is_rr(MODE);
  localparam bit HF = pick1_high_first(MODE);

  logic                   r_qvalid;
  logic [AW-1:0]          r_qaddr;
  logic [AW-1:0]          r_ptr;

  logic                   w_acc;
  logic                   w_ld;
  logic [INPUT_COUNT-1:0] w_dgrant;
  logic [INPUT_COUNT-1:0] w_cand;
  logic [INPUT_COUNT-1:0] w_mask;
  logic [INPUT_COUNT-1:0] w_hi;
  logic                   w_pri_v;
  logic [AW-1:0]          w_pri_idx;
  logic                   w_fb_v;
  logic [AW-1:0]          w_fb_idx;
  logic                   w_pick_v;
  logic [AW-1:0]          w_pick_idx;
  logic [AW-1:0]          w_ptr_nxt;

  assign w_acc = r_qvalid & qready;
  assign w_ld  = ~r_qvalid | qready;

  // The index being accepted is masked so it cannot be regranted back-to-back.
  always_comb begin
    w_dgrant = '0;
    w_mask   = '0;
    for (int i = 0; i < INPUT_COUNT; i++) begin
      w_dgrant[i] = w_acc && (r_qaddr == AW'(i));
      w_mask[i]   = RR ? (AW'(i) >= r_ptr) : 1'b1;
    end
  end

  assign w_cand = dvalid & ~w_dgrant;
  assign w_hi   = w_cand & w_mask;

  macro_pick1_arbiter_bin_pick #(
    .N          (INPUT_COUNT),
    .HIGH_FIRST (HF)
  ) u_pick_pri (
    .i_req   (w_hi),
    .o_valid (w_pri_v),
    .o_idx   (w_pri_idx)
  );

  // Round-robin wraps to the full candidate set when nothing sits at or above ptr.
  generate
    if (RR) begin : g_rr
      macro_pick1_arbiter_bin_pick #(
        .N          (INPUT_COUNT),
        .HIGH_FIRST (1'b0)
      ) u_pick_fb (
        .i_req   (w_cand),
        .o_valid (w_fb_v),
        .o_idx   (w_fb_idx)
      );
    end else begin : g_fixed
      assign w_fb_v   = 1'b0;
      assign w_fb_idx = '0;
    end
  endgenerate

  assign w_pick_v   = w_pri_v | w_fb_v;
  assign w_pick_idx = w_pri_v ? w_pri_idx : w_fb_idx;
  assign w_ptr_nxt  = (r_qaddr == AW'(INPUT_COUNT - 1)) ? '0 : r_qaddr + AW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_qvalid <= 1'b0;
      r_qaddr  <= '0;
      r_ptr    <= '0;
    end else begin
      if (w_ld) begin
        r_qvalid <= w_pick_v;
        r_qaddr  <= w_pick_v ? w_pick_idx : '0;
      end
      if (RR && w_acc)
        r_ptr <= w_ptr_nxt;
    end
  end

  assign qvalid = r_qvalid;
  assign qaddr  = r_qaddr;
  assign dgrant = w_dgrant;

`ifndef SYNTHESIS
  // A requester must keep its bit up while its grant is stalled.
  a_grant_held: assert property (@(posedge clk) disable iff (reset)
    (r_qvalid && !qready) |-> dvalid[r_qaddr])
    else $error("macro_pick1_arbiter_bin: requester %0d dropped while stalled", r_qaddr);
`endif

endmodule

// File: tb/tb_macro_pick1_arbiter_bin.sv
// Bench for macro_pick1_arbiter_bin: three instances (low-first N=4, high-first N=4,
// round-robin N=5) checked every cycle against a policy model plus directed literals.
module tb_macro_pick1_arbiter_bin;
  import macro_pick1_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] dv   [3];
  logic       qr   [3];
  bit         drop [3];
  bit         run;

  logic       qv0, qv1, qv2;
  logic [1:0] qa0, qa1;
  logic [2:0] qa2;
  logic [3:0] g0, g1;
  logic [4:0] g2;

  int a_v [3];
  int a_a [3];
  int a_g [3];
  logic [7:0] gcap [3];

  int m_qv  [3];
  int m_qa  [3];
  int m_ptr [3];
  localparam int NN [3] = '{4, 4, 5};
  localparam int MM [3] = '{PICK1_MODE_LF, PICK1_MODE_HF, PICK1_MODE_RR};

  int nvec = 0;
  int nerr = 0;

  macro_pick1_arbiter_bin #(.INPUT_COUNT(4), .MODE(PICK1_MODE_LF)) u_lf (
    .clk(clk), .reset(reset), .dvalid(dv[0][3:0]), .qready(qr[0]),
    .qvalid(qv0), .qaddr(qa0), .dgrant(g0));
  macro_pick1_arbiter_bin #(.INPUT_COUNT(4), .MODE(PICK1_MODE_HF)) u_hf (
    .clk(clk), .reset(reset), .dvalid(dv[1][3:0]), .qready(qr[1]),
    .qvalid(qv1), .qaddr(qa1), .dgrant(g1));
  macro_pick1_arbiter_bin #(.INPUT_COUNT(5), .MODE(PICK1_MODE_RR)) u_rr (
    .clk(clk), .reset(reset), .dvalid(dv[2][4:0]), .qready(qr[2]),
    .qvalid(qv2), .qaddr(qa2), .dgrant(g2));

  always_comb begin
    a_v[0] = int'(qv0); a_a[0] = int'(qa0); a_g[0] = int'(g0);
    a_v[1] = int'(qv1); a_a[1] = int'(qa1); a_g[1] = int'(g1);
    a_v[2] = int'(qv2); a_a[2] = int'(qa2); a_g[2] = int'(g2);
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Policy model: first requester found scanning low-to-high, high-to-low,
  // or circularly starting at the round-robin pointer.
  function automatic int pick(input int mode, input int n, input logic [7:0] cand, input int ptr);
    int j;
    if (mode == PICK1_MODE_HF) begin
      for (int i = n - 1; i >= 0; i--) if (cand[i]) return i;
    end else begin
      for (int s = 0; s < n; s++) begin
        j = (mode == PICK1_MODE_RR) ? (ptr + s) % n : s;
        if (cand[j]) return j;
      end
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit         acc;
      logic [7:0] cand;
      int         p;
      acc  = (m_qv[k] != 0) && (qr[k] == 1'b1);
      cand = dv[k] & ~(acc ? (8'(1) << m_qa[k]) : 8'h00);
      p    = pick(MM[k], NN[k], cand, m_ptr[k]);
      if (reset) begin
        m_qv[k]  <= 0;
        m_qa[k]  <= 0;
        m_ptr[k] <= 0;
      end else begin
        if (m_qv[k] == 0 || qr[k]) begin
          m_qv[k] <= (p >= 0) ? 1 : 0;
          m_qa[k] <= (p >= 0) ? p : 0;
        end
        if (acc && MM[k] == PICK1_MODE_RR)
          m_ptr[k] <= (m_qa[k] + 1) % NN[k];
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) gcap[k] <= 8'(a_g[k]);
    if (run) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_qvalid%0d", k), a_v[k], m_qv[k]);
        chk($sformatf("model_qaddr%0d", k), a_a[k], m_qa[k]);
        chk($sformatf("model_dgrant%0d", k), a_g[k],
            (m_qv[k] != 0 && qr[k]) ? (1 << m_qa[k]) : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) if (drop[k]) dv[k] = dv[k] & ~gcap[k];
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dv[k] = 8'h00; qr[k] = 1'b1; drop[k] = 1'b0;
    end
    tick(); run = 1'b1;
    tick(); reset = 1'b0;
    mid();
    chk("rst_qvalid_lf", a_v[0], 0); chk("rst_qaddr_lf", a_a[0], 0);
    chk("rst_dgrant_lf", a_g[0], 0); chk("rst_qvalid_rr", a_v[2], 0);

    // Two requesters, each dropping on its grant.
    tick(); dv[0] = 8'b1010; dv[1] = 8'b1010; drop[0] = 1'b1; drop[1] = 1'b1;
    tick(); mid();
    chk("lf_first", a_a[0], 1); chk("lf_first_g", a_g[0], 2);
    chk("hf_first", a_a[1], 3); chk("hf_first_g", a_g[1], 8);
    tick(); mid();
    chk("lf_second", a_a[0], 3); chk("hf_second", a_a[1], 1);
    tick(); mid();
    chk("lf_idle", a_v[0], 0); chk("hf_idle", a_v[1], 0);
    drop[0] = 1'b0; drop[1] = 1'b0;

    // Round-robin on five held requesters walks 0..4 and wraps.
    tick(); dv[2] = 8'h1F;
    for (int k = 0; k < 7; k++) begin
      tick(); mid();
      chk($sformatf("rr_seq%0d", k), a_a[2], k % 5);
      chk($sformatf("rr_seq_g%0d", k), a_g[2], 1 << (k % 5));
    end
    dv[2] = 8'h00;
    tick(); tick();

    // Round-robin stalled: ptr is 2, so index 4 wins over 1, then 1 after the wrap.
    tick(); dv[2] = 8'b10010; qr[2] = 1'b0; drop[2] = 1'b1;
    tick(); mid(); chk("rr_skip", a_a[2], 4);
    repeat (3) begin tick(); mid(); chk("rr_stall_hold", a_a[2], 4); end
    tick(); qr[2] = 1'b1; mid(); chk("rr_stall_g", a_g[2], 16);
    tick(); mid(); chk("rr_after_wrap", a_a[2], 1);
    tick(); tick(); drop[2] = 1'b0;

    // Stall with changing requests.
    tick(); dv[0] = 8'b0100; qr[0] = 1'b0;
    tick(); mid();
    chk("stall_qv", a_v[0], 1); chk("stall_qa", a_a[0], 2); chk("stall_g", a_g[0], 0);
    dv[0] = 8'b0101;
    repeat (5) begin
      tick(); mid();
      chk("stall_hold_qa", a_a[0], 2); chk("stall_hold_g", a_g[0], 0);
    end
    tick(); qr[0] = 1'b1; drop[0] = 1'b1; mid();
    chk("stall_release_g", a_g[0], 4);
    tick(); mid(); chk("stall_next_qa", a_a[0], 0); chk("stall_next_g", a_g[0], 1);
    tick(); tick(); drop[0] = 1'b0;

    // Single requester held: grant every other cycle.
    tick(); dv[0] = 8'b0001;
    for (int k = 0; k < 6; k++) begin
      tick(); mid();
      chk($sformatf("single_qv%0d", k), a_v[0], (k % 2 == 0) ? 1 : 0);
      chk($sformatf("single_g%0d", k), a_g[0], (k % 2 == 0) ? 1 : 0);
    end
    dv[0] = 8'h00;
    tick(); tick();

    // Reset while a grant is held.
    tick(); dv[0] = 8'b1000; qr[0] = 1'b0;
    tick(); mid(); chk("rstg_qv", a_v[0], 1); chk("rstg_qa", a_a[0], 3);
    tick(); reset = 1'b1; mid(); chk("rstg_during_g", a_g[0], 0);
    tick(); reset = 1'b0; mid();
    chk("rstg_after_qv", a_v[0], 0); chk("rstg_after_qa", a_a[0], 0);
    chk("rstg_after_g", a_g[0], 0);
    tick(); mid(); chk("rstg_return_qv", a_v[0], 1); chk("rstg_return_qa", a_a[0], 3);
    tick(); qr[0] = 1'b1; drop[0] = 1'b1; mid(); chk("rstg_accept_g", a_g[0], 8);
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
